// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA timing constants, mode struct and total/width helpers
// Default mode is 640x480@60 with a 25 MHz pixel clock.
package vga_timing_pkg;

  typedef struct packed {
    int display;
    int front;
    int sync;
    int back;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_mode_t;

  localparam int VGA640_PIX_CLK_HZ = 25_000_000;

  localparam int VGA640_H_DISPLAY = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_DISPLAY = 480;
  localparam int VGA640_V_FRONT   = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BACK    = 33;

  localparam vga_mode_t VGA640_MODE = '{
    h: '{VGA640_H_DISPLAY, VGA640_H_FRONT, VGA640_H_SYNC, VGA640_H_BACK},
    v: '{VGA640_V_DISPLAY, VGA640_V_FRONT, VGA640_V_SYNC, VGA640_V_BACK}
  };

  function automatic int vga_axis_total(input vga_axis_t a);
    return a.display + a.front + a.sync + a.back;
  endfunction

  // Counters need at least one bit even for degenerate totals.
  function automatic int vga_cnt_width(input int total);
    return (total > 2) ? $clog2(total) : 1;
  endfunction

  localparam int VGA640_H_TOTAL = vga_axis_total(VGA640_MODE.h);
  localparam int VGA640_V_TOTAL = vga_axis_total(VGA640_MODE.v);

endpackage

// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - raster timing bundle: run control in, position/sync/strobes out
// irq_line/line_irq exist only when VGA_TIMING_LINE_IRQ_EN is defined.
interface vga_timing_if #(
  parameter int HW = 10,
  parameter int VW = 10
);

  logic          enable;
  logic          pix_stb;
  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;
  logic          hsync;
  logic          vsync;
  logic          display_on;
  logic          vblank;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_TIMING_LINE_IRQ_EN
  logic [VW-1:0] irq_line;
  logic          line_irq;

  modport master (
    input  enable, irq_line,
    output pix_stb, hpos, vpos, hsync, vsync, display_on, vblank,
           line_start, frame_start, line_irq
  );

  modport slave (
    output enable, irq_line,
    input  pix_stb, hpos, vpos, hsync, vsync, display_on, vblank,
           line_start, frame_start, line_irq
  );
`else
  modport master (
    input  enable,
    output pix_stb, hpos, vpos, hsync, vsync, display_on, vblank,
           line_start, frame_start
  );

  modport slave (
    output enable,
    input  pix_stb, hpos, vpos, hsync, vsync, display_on, vblank,
           line_start, frame_start
  );
`endif

endinterface

// File: rtl/vga_pix_div.sv
// rtl/vga_pix_div.sv - clk-to-pixel divider producing a one-clk pix_stb every CLK_DIV enabled clks
module vga_pix_div #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  output logic pix_stb_o
);

  localparam int            DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt_q;
  logic [DW-1:0] cnt_d;
  logic          at_last;

  always_comb begin
    at_last = (cnt_q == LAST);
    cnt_d   = cnt_q;
    if (enable_i) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Gated by rst so no strobe leaks out while held in reset with CLK_DIV=1.
  assign pix_stb_o = enable_i & at_last & ~rst;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: position counters, sync/blank decode, line/frame strobes
// Optional line-match interrupt built when VGA_TIMING_LINE_IRQ_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = VGA640_H_DISPLAY,
  parameter int H_FRONT   = VGA640_H_FRONT,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BACK    = VGA640_H_BACK,
  parameter int V_DISPLAY = VGA640_V_DISPLAY,
  parameter int V_FRONT   = VGA640_V_FRONT,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BACK    = VGA640_V_BACK,
  parameter int CLK_DIV   = 1,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  vga_timing_if.master vga
);

  localparam vga_axis_t H_AXIS  = '{H_DISPLAY, H_FRONT, H_SYNC, H_BACK};
  localparam vga_axis_t V_AXIS  = '{V_DISPLAY, V_FRONT, V_SYNC, V_BACK};
  localparam int        H_TOTAL = vga_axis_total(H_AXIS);
  localparam int        V_TOTAL = vga_axis_total(V_AXIS);
  localparam int        HW      = vga_cnt_width(H_TOTAL);
  localparam int        VW      = vga_cnt_width(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_DISPLAY);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_DISPLAY + H_FRONT);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_DISPLAY);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_DISPLAY + V_FRONT);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic          pix_stb;
  logic          h_last;
  logic          v_last;
  logic          line_start;
  logic          frame_start;
  logic [HW-1:0] hpos_q;
  logic [HW-1:0] hpos_d;
  logic [VW-1:0] vpos_q;
  logic [VW-1:0] vpos_d;
  logic          hsync_q;
  logic          hsync_d;
  logic          vsync_q;
  logic          vsync_d;
  logic          display_on_q;
  logic          display_on_d;
  logic          vblank_q;
  logic          vblank_d;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk       (clk),
    .rst       (reset),
    .enable_i  (vga.enable),
    .pix_stb_o (pix_stb)
  );

  always_comb begin
    h_last      = (hpos_q == H_LAST);
    v_last      = (vpos_q == V_LAST);
    line_start  = pix_stb & h_last;
    frame_start = line_start & v_last;
    hpos_d      = hpos_q;
    vpos_d      = vpos_q;
    if (pix_stb) begin
      hpos_d = h_last ? '0 : hpos_q + 1'b1;
      if (h_last) begin
        vpos_d = v_last ? '0 : vpos_q + 1'b1;
      end
    end
  end

  // Decode samples the position before it advances, so outputs trail hpos/vpos by one pixel.
  always_comb begin
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    display_on_d = display_on_q;
    vblank_d     = vblank_q;
    if (pix_stb) begin
      hsync_d      = ((hpos_q >= HS_FIRST) && (hpos_q <= HS_LAST)) ? H_POL : ~H_POL;
      vsync_d      = ((vpos_q >= VS_FIRST) && (vpos_q <= VS_LAST)) ? V_POL : ~V_POL;
      display_on_d = (hpos_q < H_VIS) && (vpos_q < V_VIS);
      vblank_d     = (vpos_q >= V_VIS);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos_q       <= '0;
      vpos_q       <= '0;
      hsync_q      <= ~H_POL;
      vsync_q      <= ~V_POL;
      display_on_q <= 1'b0;
      vblank_q     <= 1'b0;
    end else begin
      hpos_q       <= hpos_d;
      vpos_q       <= vpos_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      display_on_q <= display_on_d;
      vblank_q     <= vblank_d;
    end
  end

  assign vga.pix_stb     = pix_stb;
  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.display_on  = display_on_q;
  assign vga.vblank      = vblank_q;
  assign vga.line_start  = line_start;
  assign vga.frame_start = frame_start;

`ifdef VGA_TIMING_LINE_IRQ_EN
  // vpos_d is the line being entered when line_start fires.
  assign vga.line_irq = line_start & (vpos_d == vga.irq_line);
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized bench for vga_timing_gen against an arithmetic raster model
// Set VGA_TIMING_LINE_IRQ_EN to also cover the line-match interrupt.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0;
  logic rst1;
  logic rst2;

  vga_timing_if #(.HW(10), .VW(10)) if0 ();
  vga_timing_if #(.HW(4),  .VW(3))  if1 ();
  vga_timing_if #(.HW(4),  .VW(3))  if2 ();

  vga_timing_gen u_dut0 (
    .clk   (clk),
    .reset (rst0),
    .vga   (if0)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(3)
  ) u_dut1 (
    .clk   (clk),
    .reset (rst1),
    .vga   (if1)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(2), .H_POL(1'b1), .V_POL(1'b1)
  ) u_dut2 (
    .clk   (clk),
    .reset (rst2),
    .vga   (if2)
  );

  // Mode table mirrored per instance; model works purely from these numbers.
  int m_hd  [3] = '{640, 8, 8};
  int m_hf  [3] = '{16,  2, 2};
  int m_hs  [3] = '{96,  2, 2};
  int m_hb  [3] = '{48,  2, 2};
  int m_vd  [3] = '{480, 4, 4};
  int m_vf  [3] = '{10,  1, 1};
  int m_vs  [3] = '{2,   1, 1};
  int m_vb  [3] = '{33,  1, 1};
  int m_div [3] = '{1,   3, 2};
  int m_hp  [3] = '{0,   0, 1};
  int m_vp  [3] = '{0,   0, 1};
  int irq_tgt [3] = '{0, 2, 6};

  int n_clk [3];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int phase = 0;

  int last_ls0 = -1;
  int last_ps1 = -1;
  int last_ls1 = -1;
  int last_fs1 = -1;
  int prev_hp1 = 0;
  bit prev_hs0 = 1'b1;
  int hs_low0  = 0;
  int irq_cnt1 = 0;
  int irq_cnt2 = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Elapsed enabled clks since reset fully determine the raster state.
  task automatic compare(input int i, input bit rst, input bit en, input int hp, input int vp,
                         input bit hs, input bit vs, input bit de, input bit vb,
                         input bit ps, input bit ls, input bit fs, input bit irq);
    int ht, vt, p, q, qh, qv, e_h, e_v, hs0, vs0;
    bit e_hs, e_vs, e_de, e_vb, e_ps, e_ls, e_fs, e_irq;
    string t;
    ht  = m_hd[i] + m_hf[i] + m_hs[i] + m_hb[i];
    vt  = m_vd[i] + m_vf[i] + m_vs[i] + m_vb[i];
    hs0 = m_hd[i] + m_hf[i];
    vs0 = m_vd[i] + m_vf[i];
    if (rst) n_clk[i] = 0;
    p     = n_clk[i] / m_div[i];
    e_h   = p % ht;
    e_v   = (p / ht) % vt;
    e_ps  = !rst && en && ((n_clk[i] % m_div[i]) == m_div[i] - 1);
    e_ls  = e_ps && (e_h == ht - 1);
    e_fs  = e_ls && (e_v == vt - 1);
    e_irq = e_ls && (((e_v + 1) % vt) == irq_tgt[i]);
    if (p == 0) begin
      e_hs = !m_hp[i][0];
      e_vs = !m_vp[i][0];
      e_de = 1'b0;
      e_vb = 1'b0;
    end else begin
      q    = p - 1;
      qh   = q % ht;
      qv   = (q / ht) % vt;
      e_hs = (qh >= hs0 && qh < hs0 + m_hs[i]) ? m_hp[i][0] : !m_hp[i][0];
      e_vs = (qv >= vs0 && qv < vs0 + m_vs[i]) ? m_vp[i][0] : !m_vp[i][0];
      e_de = (qh < m_hd[i]) && (qv < m_vd[i]);
      e_vb = (qv >= m_vd[i]);
    end
    t = $sformatf("u%0d_", i);
    check_eq({t, "hpos"},        hp,      e_h);
    check_eq({t, "vpos"},        vp,      e_v);
    check_eq({t, "hsync"},       int'(hs), int'(e_hs));
    check_eq({t, "vsync"},       int'(vs), int'(e_vs));
    check_eq({t, "display_on"},  int'(de), int'(e_de));
    check_eq({t, "vblank"},      int'(vb), int'(e_vb));
    check_eq({t, "pix_stb"},     int'(ps), int'(e_ps));
    check_eq({t, "line_start"},  int'(ls), int'(e_ls));
    check_eq({t, "frame_start"}, int'(fs), int'(e_fs));
`ifdef VGA_TIMING_LINE_IRQ_EN
    check_eq({t, "line_irq"},    int'(irq), int'(e_irq));
`else
    if (irq) check_eq({t, "line_irq_absent"}, int'(irq), 0);
`endif
  endtask

  task automatic step();
    bit irq0, irq1, irq2;
    @(negedge clk);
`ifdef VGA_TIMING_LINE_IRQ_EN
    irq0 = if0.line_irq;
    irq1 = if1.line_irq;
    irq2 = if2.line_irq;
`else
    irq0 = 1'b0;
    irq1 = 1'b0;
    irq2 = 1'b0;
`endif
    compare(0, rst0, if0.enable, int'(if0.hpos), int'(if0.vpos), if0.hsync, if0.vsync,
            if0.display_on, if0.vblank, if0.pix_stb, if0.line_start, if0.frame_start, irq0);
    compare(1, rst1, if1.enable, int'(if1.hpos), int'(if1.vpos), if1.hsync, if1.vsync,
            if1.display_on, if1.vblank, if1.pix_stb, if1.line_start, if1.frame_start, irq1);
    compare(2, rst2, if2.enable, int'(if2.hpos), int'(if2.vpos), if2.hsync, if2.vsync,
            if2.display_on, if2.vblank, if2.pix_stb, if2.line_start, if2.frame_start, irq2);
    if (phase == 1) begin
      if (if0.line_start) begin
        if (last_ls0 >= 0) check_eq("u0_line_period", cyc - last_ls0, 800);
        last_ls0 = cyc;
      end
      if (!if0.hsync) begin
        if (prev_hs0) begin
          check_eq("u0_hsync_fall_hpos", int'(if0.hpos), 657);
          hs_low0 = 1;
        end else begin
          hs_low0++;
        end
      end else if (!prev_hs0) begin
        check_eq("u0_hsync_low_len", hs_low0, 96);
      end
      prev_hs0 = if0.hsync;
      if (if1.pix_stb) begin
        if (last_ps1 >= 0) check_eq("u1_pix_period", cyc - last_ps1, 3);
        last_ps1 = cyc;
      end
      if (if1.line_start) begin
        if (last_ls1 >= 0) check_eq("u1_line_period", cyc - last_ls1, 42);
        last_ls1 = cyc;
      end
      if (if1.frame_start) begin
        if (last_fs1 >= 0) check_eq("u1_frame_period", cyc - last_fs1, 294);
        last_fs1 = cyc;
        check_eq("u1_frame_implies_line", int'(if1.line_start), 1);
      end
      if (int'(if1.hpos) != prev_hp1 && if1.hpos == 4'd0) check_eq("u1_wrap_from", prev_hp1, 13);
      prev_hp1 = int'(if1.hpos);
      if (if2.hpos == 4'd11) check_eq("u2_hsync_active", int'(if2.hsync), 1);
      if (if2.vpos == 3'd5 && if2.hpos == 4'd3) check_eq("u2_vsync_active", int'(if2.vsync), 1);
`ifdef VGA_TIMING_LINE_IRQ_EN
      if (irq1) irq_cnt1++;
      if (irq2) irq_cnt2++;
      if (if1.frame_start) begin
        check_eq("u1_irq_per_frame", irq_cnt1, 1);
        irq_cnt1 = 0;
      end
      if (if2.frame_start) begin
        check_eq("u2_irq_per_frame", irq_cnt2, 1);
        irq_cnt2 = 0;
      end
`endif
    end
    @(posedge clk);
    if (rst0) n_clk[0] = 0; else if (if0.enable) n_clk[0]++;
    if (rst1) n_clk[1] = 0; else if (if1.enable) n_clk[1]++;
    if (rst2) n_clk[2] = 0; else if (if2.enable) n_clk[2]++;
    cyc++;
    #1;
  endtask

  initial begin
    int found;
    rst0 = 1'b1;
    rst1 = 1'b1;
    rst2 = 1'b1;
    if0.enable = 1'b1;
    if1.enable = 1'b1;
    if2.enable = 1'b1;
`ifdef VGA_TIMING_LINE_IRQ_EN
    if0.irq_line = 10'(irq_tgt[0]);
    if1.irq_line = 3'(irq_tgt[1]);
    if2.irq_line = 3'(irq_tgt[2]);
`endif
    for (int k = 0; k < 3; k++) step();
    check_eq("u2_hsync_idle_rst", int'(if2.hsync), 0);
    check_eq("u2_vsync_idle_rst", int'(if2.vsync), 0);
    check_eq("u0_pix_stb_rst", int'(if0.pix_stb), 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    rst2 = 1'b0;

    phase = 1;
    for (int k = 0; k < 3000; k++) step();
    phase = 2;

    found = 0;
    for (int k = 0; k < 60 && found == 0; k++) begin
      if (if1.hpos == 4'd5) found = 1;
      else step();
    end
    check_eq("u1_reach_hpos5", found, 1);
    if1.enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check_eq("u1_hold_hpos", int'(if1.hpos), 5);
      check_eq("u1_hold_stb", int'(if1.pix_stb) + int'(if1.line_start) + int'(if1.frame_start), 0);
    end
    if1.enable = 1'b1;
    found = 0;
    for (int k = 0; k < 6 && found == 0; k++) begin
      if (if1.pix_stb) found = 1;
      step();
    end
    check_eq("u1_resume_stb", found, 1);
    check_eq("u1_resume_hpos", int'(if1.hpos), 6);

    found = 0;
    for (int k = 0; k < 400 && found == 0; k++) begin
      if (if1.hpos == 4'd7 && if1.vpos == 3'd3 && !if1.pix_stb) found = 1;
      else step();
    end
    check_eq("u1_reach_7_3", found, 1);
    rst1 = 1'b1;
    #1;
    check_eq("u1_async_hpos", int'(if1.hpos), 0);
    check_eq("u1_async_vpos", int'(if1.vpos), 0);
    check_eq("u1_async_hsync", int'(if1.hsync), 1);
    check_eq("u1_async_de", int'(if1.display_on), 0);
    step();
    step();
    rst1 = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check_eq("u1_restart_hpos", int'(if1.hpos), 1);
    check_eq("u1_restart_vpos", int'(if1.vpos), 0);

    phase = 4;
    for (int c = 0; c < 20000; c++) begin
      if0.enable = ($urandom_range(0, 3) != 0);
      if1.enable = ($urandom_range(0, 3) != 0);
      if2.enable = ($urandom_range(0, 3) != 0);
      rst0 = ($urandom_range(0, 2999) == 0);
      rst1 = ($urandom_range(0, 299) == 0);
      rst2 = ($urandom_range(0, 299) == 0);
`ifdef VGA_TIMING_LINE_IRQ_EN
      if ($urandom_range(0, 99) == 0) begin
        irq_tgt[1]   = int'($urandom_range(0, 6));
        if1.irq_line = 3'(irq_tgt[1]);
      end
`endif
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
